// File: rtl/ofs_fim_pcie_pkg.sv
// Shared PCIe TX arbitration constants and types.
package ofs_fim_pcie_pkg;

  localparam int unsigned MAX_MRD_DW     = 1024;
  localparam int unsigned MRD_LEN_W      = $clog2(MAX_MRD_DW + 1);
  localparam int unsigned CPL_BUF_DW_DEF = 4096;
  localparam int unsigned CPL_CREDIT_W   = $clog2(CPL_BUF_DW_DEF + 1);

  typedef logic [CPL_CREDIT_W-1:0] t_cpl_credit;
  typedef logic [MRD_LEN_W-1:0]    t_mrd_len;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } t_arb_state;

endpackage

// File: rtl/pcie_tx_rr_arb.sv
// Combinational round-robin picker: first eligible index at or after rr_ptr.
module pcie_tx_rr_arb #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] grant,
  output logic             found
);

  logic [IDX_W:0] cand;

  // Scan N candidates starting at rr_ptr, wrapping modulo N
  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (IDX_W+1)'(rr_ptr) + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N)) begin
        cand = cand - (IDX_W+1)'(N);
      end
      if (!found && eligible[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        grant = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/pcie_tx_arb_ptile.sv
// Packet-atomic round-robin TX arbiter with completion-buffer gating of MRd.
module pcie_tx_arb_ptile
  import ofs_fim_pcie_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_W     = 512,
  parameter int unsigned CPL_BUF_DW = CPL_BUF_DW_DEF,
  parameter int unsigned CREDIT_W   = $clog2(CPL_BUF_DW + 1)
) (
  input  logic                           avl_clk,
  input  logic                           avl_rst,
  input  logic [NUM_REQ-1:0]             req_tvalid,
  output logic [NUM_REQ-1:0]             req_tready,
  input  logic [NUM_REQ*DATA_W-1:0]      req_tdata,
  input  logic [NUM_REQ-1:0]             req_tlast,
  input  logic [NUM_REQ-1:0]             req_sop,
  input  logic [NUM_REQ-1:0]             req_mrd,
  input  logic [NUM_REQ*MRD_LEN_W-1:0]   req_mrd_len,
  output logic                           out_tvalid,
  input  logic                           out_tready,
  output logic [DATA_W-1:0]              out_tdata,
  output logic                           out_tlast,
  output logic [$clog2(NUM_REQ)-1:0]     out_src,
  output logic                           mrd_issue_valid,
  output logic [MRD_LEN_W-1:0]           mrd_issue_len,
  input  logic                           cpl_drain_valid,
  input  logic [MRD_LEN_W-1:0]           cpl_drain_len,
  output logic [CREDIT_W-1:0]            pending_dw,
  output logic                           err_underflow
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  // Wide enough for pending + any 11-bit length without wrap
  localparam int unsigned SUM_W = ((CREDIT_W > MRD_LEN_W) ? CREDIT_W : MRD_LEN_W) + 1;

  t_arb_state        state;
  logic [IDX_W-1:0]  grant;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_found;
  logic [NUM_REQ-1:0] elig;
  logic              xfer;
  logic              grant_mrd;
  t_mrd_len          gnt_len;
  logic [SUM_W-1:0]  inc;
  logic [SUM_W-1:0]  dec;
  logic [SUM_W-1:0]  sum;
  logic              underflow;
  logic [CREDIT_W-1:0] pending_next;

  t_mrd_len          len_arr  [NUM_REQ];
  logic [DATA_W-1:0] data_arr [NUM_REQ];

  // Per-source unpacking and eligibility against the registered pending count
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_src
    assign len_arr[g]  = req_mrd_len[g*MRD_LEN_W +: MRD_LEN_W];
    assign data_arr[g] = req_tdata[g*DATA_W +: DATA_W];
    assign elig[g]     = req_tvalid[g] & req_sop[g] &
                         (~req_mrd[g] |
                          ((SUM_W'(pending_dw) + SUM_W'(len_arr[g])) <= SUM_W'(CPL_BUF_DW)));
  end

  pcie_tx_rr_arb #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arb (
    .eligible (elig),
    .rr_ptr   (rr_ptr),
    .grant    (arb_idx),
    .found    (arb_found)
  );

  assign xfer       = (state == ARB_XFER);
  assign out_src    = grant;
  assign out_tvalid = xfer & req_tvalid[grant];
  assign out_tlast  = xfer & req_tlast[grant];
  assign out_tdata  = data_arr[grant];

  // Only the granted source sees the bridge ready, and only while transferring
  always_comb begin
    req_tready = '0;
    if (xfer) begin
      req_tready[grant] = out_tready;
    end
  end

  // Pending-DW arithmetic: reserve on MRd grant, release on drain, clamp at zero
  always_comb begin
    gnt_len      = len_arr[arb_idx];
    grant_mrd    = (state == ARB_IDLE) & arb_found & req_mrd[arb_idx];
    inc          = grant_mrd ? SUM_W'(gnt_len) : '0;
    dec          = cpl_drain_valid ? SUM_W'(cpl_drain_len) : '0;
    sum          = SUM_W'(pending_dw) + inc;
    underflow    = (dec > sum);
    pending_next = underflow ? '0 : CREDIT_W'(sum - dec);
  end

  // Arbitration FSM, grant/pointer registers and completion credit counter
  always_ff @(posedge avl_clk) begin
    if (avl_rst) begin
      state           <= ARB_IDLE;
      grant           <= '0;
      rr_ptr          <= '0;
      mrd_issue_valid <= 1'b0;
      mrd_issue_len   <= '0;
      pending_dw      <= '0;
      err_underflow   <= 1'b0;
    end else begin
      mrd_issue_valid <= 1'b0;
      pending_dw      <= pending_next;
      if (underflow) begin
        err_underflow <= 1'b1;
      end
      case (state)
        ARB_IDLE: begin
          if (arb_found) begin
            grant <= arb_idx;
            state <= ARB_XFER;
            if (req_mrd[arb_idx]) begin
              mrd_issue_valid <= 1'b1;
              mrd_issue_len   <= gnt_len;
            end
          end
        end
        ARB_XFER: begin
          if (out_tvalid && out_tready && out_tlast) begin
            rr_ptr <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + IDX_W'(1);
            state  <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_tx_arb_ptile.sv
// Bench for pcie_tx_arb_ptile: directed scenarios, a counter vector table and
// randomized traffic checked against a cycle-level behavioural model.
module tb_pcie_tx_arb_ptile;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int BUF = 4096;
  localparam int CW  = 13;

  logic              avl_clk = 1'b0;
  logic              avl_rst;
  logic [N-1:0]      req_tvalid, req_tready, req_tlast, req_sop, req_mrd;
  logic [N*DW-1:0]   req_tdata;
  logic [N*11-1:0]   req_mrd_len;
  logic              out_tvalid, out_tready, out_tlast;
  logic [DW-1:0]     out_tdata;
  logic [1:0]        out_src;
  logic              mrd_issue_valid;
  logic [10:0]       mrd_issue_len;
  logic              cpl_drain_valid;
  logic [10:0]       cpl_drain_len;
  logic [CW-1:0]     pending_dw;
  logic              err_underflow;

  pcie_tx_arb_ptile #(
    .NUM_REQ(N), .DATA_W(DW), .CPL_BUF_DW(BUF), .CREDIT_W(CW)
  ) dut (
    .avl_clk(avl_clk), .avl_rst(avl_rst),
    .req_tvalid(req_tvalid), .req_tready(req_tready), .req_tdata(req_tdata),
    .req_tlast(req_tlast), .req_sop(req_sop), .req_mrd(req_mrd),
    .req_mrd_len(req_mrd_len),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
    .out_tlast(out_tlast), .out_src(out_src),
    .mrd_issue_valid(mrd_issue_valid), .mrd_issue_len(mrd_issue_len),
    .cpl_drain_valid(cpl_drain_valid), .cpl_drain_len(cpl_drain_len),
    .pending_dw(pending_dw), .err_underflow(err_underflow)
  );

  always #5 avl_clk = ~avl_clk;

  typedef struct {int nb; bit mrd; int len; int id;} pkt_t;
  typedef struct {int len; int drain; int exp_pend; bit exp_err; bit exp_issue;} cvec_t;

  pkt_t fifo [N][64];
  int   hd [N];
  int   tl [N];
  int   beat [N];
  bit   bub [N];
  int   id_ctr;

  int vectors, miscompares, cyc;

  bit rst_now, rdy_now, dv_now, chk_en, bubbles_en;
  int dl_now;

  // behavioural model state
  bit m_busy, m_err, m_issue;
  int m_src, m_ptr, m_pend, m_ilen;

  // observation
  int   glog_src [$];
  int   glog_cyc [$];
  bit   out_first;
  int   out_hs_cnt;
  bit   stall_chk_en, stall_hold;
  logic [DW-1:0] stall_data;
  logic stall_last;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int qcnt(int i);
    return tl[i] - hd[i];
  endfunction

  function automatic bit any_queued();
    for (int i = 0; i < N; i++) if (qcnt(i) > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push(int i, int n_b, bit is_mrd, int l);
    fifo[i][tl[i] % 64] = '{nb: n_b, mrd: is_mrd, len: l, id: id_ctr};
    id_ctr++;
    tl[i]++;
  endtask

  function automatic logic [DW-1:0] mk(int i, int id, int b);
    return {8'(i), 16'(id), 8'(b)};
  endfunction

  task automatic drive();
    pkt_t p;
    for (int i = 0; i < N; i++) begin
      if (qcnt(i) > 0 && !bub[i]) begin
        p = fifo[i][hd[i] % 64];
        req_tvalid[i] = 1'b1;
        req_sop[i]    = (beat[i] == 0);
        req_tlast[i]  = (beat[i] == p.nb - 1);
        req_mrd[i]    = p.mrd;
        req_mrd_len[i*11 +: 11] = 11'(p.len);
        req_tdata[i*DW +: DW]   = mk(i, p.id, beat[i]);
      end else begin
        req_tvalid[i] = 1'b0;
        req_sop[i]    = 1'b0;
        req_tlast[i]  = 1'b0;
        req_mrd[i]    = 1'b0;
        req_mrd_len[i*11 +: 11] = '0;
        req_tdata[i*DW +: DW]   = '0;
      end
    end
  endtask

  // One clock: drive, sample at negedge, check, advance the model and sources
  task automatic cycle();
    bit hs [N];
    bit found, exp_v;
    int inc, dec, p, idx, l;
    for (int i = 0; i < N; i++) bub[i] = bubbles_en && ($urandom % 4 == 0);
    drive();
    avl_rst         = rst_now;
    out_tready      = rdy_now;
    cpl_drain_valid = dv_now;
    cpl_drain_len   = 11'(dl_now);
    @(negedge avl_clk);
    if (chk_en) begin
      exp_v = m_busy && req_tvalid[m_src];
      chk("out_tvalid", 64'(out_tvalid), 64'(exp_v));
      chk("req_tready", 64'(req_tready), (m_busy && rdy_now) ? (64'(1) << m_src) : 64'(0));
      chk("out_src", 64'(out_src), 64'(m_src));
      chk("pending_dw", 64'(pending_dw), 64'(m_pend));
      chk("err_underflow", 64'(err_underflow), 64'(m_err));
      chk("mrd_issue_valid", 64'(mrd_issue_valid), 64'(m_issue));
      chk("mrd_issue_len", 64'(mrd_issue_len), 64'(m_ilen));
      if (exp_v) begin
        chk("out_tdata", 64'(out_tdata), 64'(req_tdata[m_src*DW +: DW]));
        chk("out_tlast", 64'(out_tlast), 64'(req_tlast[m_src]));
      end
    end
    if (stall_chk_en) begin
      if (stall_hold) begin
        chk("stall_data", 64'(out_tdata), 64'(stall_data));
        chk("stall_last", 64'(out_tlast), 64'(stall_last));
      end
      stall_hold = out_tvalid && !out_tready;
      stall_data = out_tdata;
      stall_last = out_tlast;
    end
    if (out_tvalid && out_tready) begin
      out_hs_cnt++;
      if (out_first) begin
        glog_src.push_back(int'(out_src));
        glog_cyc.push_back(cyc);
      end
      out_first = out_tlast;
    end
    for (int i = 0; i < N; i++) hs[i] = req_tvalid[i] && req_tready[i];
    // model: packet-atomic round robin plus credit arithmetic
    m_issue = 1'b0;
    inc = 0;
    dec = dv_now ? dl_now : 0;
    if (m_busy) begin
      if (req_tvalid[m_src] && rdy_now && req_tlast[m_src]) begin
        m_busy = 1'b0;
        m_ptr  = (m_src + 1) % N;
      end
    end else begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        l   = int'(req_mrd_len[idx*11 +: 11]);
        if (!found && req_tvalid[idx] && req_sop[idx] &&
            (!req_mrd[idx] || (m_pend + l <= BUF))) begin
          found  = 1'b1;
          m_busy = 1'b1;
          m_src  = idx;
          if (req_mrd[idx]) begin
            inc     = l;
            m_issue = 1'b1;
            m_ilen  = l;
          end
        end
      end
    end
    p = m_pend + inc - dec;
    if (p < 0) begin
      p = 0;
      m_err = 1'b1;
    end
    m_pend = p;
    if (rst_now) begin
      m_busy = 0; m_src = 0; m_ptr = 0; m_pend = 0;
      m_err = 0; m_issue = 0; m_ilen = 0;
      out_first = 1'b1;
    end
    @(posedge avl_clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (rst_now) begin
        hd[i]   = tl[i];
        beat[i] = 0;
      end else if (hs[i]) begin
        beat[i]++;
        if (beat[i] == fifo[i][hd[i] % 64].nb) begin
          beat[i] = 0;
          hd[i]++;
        end
      end
    end
    cyc++;
  endtask

  task automatic run_n(int n);
    for (int c = 0; c < n; c++) cycle();
  endtask

  task automatic run_idle(int maxc);
    int c;
    c = 0;
    while ((any_queued() || m_busy) && c < maxc) begin
      cycle();
      c++;
    end
    if (any_queued() || m_busy) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout cyc=%0d: still busy after %0d cycles", cyc, maxc);
    end
  endtask

  task automatic drain_all();
    for (int c = 0; c < 40 && m_pend > 0; c++) begin
      dv_now = 1'b1;
      dl_now = (m_pend > 1024) ? 1024 : m_pend;
      cycle();
    end
    dv_now = 1'b0;
  endtask

  task automatic clear_log();
    glog_src.delete();
    glog_cyc.delete();
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_out_tvalid"}, 64'(out_tvalid), 64'(0));
    chk({tag, "_req_tready"}, 64'(req_tready), 64'(0));
    chk({tag, "_out_src"}, 64'(out_src), 64'(0));
    chk({tag, "_pending_dw"}, 64'(pending_dw), 64'(0));
    chk({tag, "_err"}, 64'(err_underflow), 64'(0));
    chk({tag, "_issue_valid"}, 64'(mrd_issue_valid), 64'(0));
    chk({tag, "_issue_len"}, 64'(mrd_issue_len), 64'(0));
  endtask

  initial begin
    cvec_t cv [6];
    int base;
    cv[0] = '{len: 100, drain: 0,  exp_pend: 100, exp_err: 0, exp_issue: 1};
    cv[1] = '{len: 16,  drain: 16, exp_pend: 100, exp_err: 0, exp_issue: 1};
    cv[2] = '{len: 0,   drain: 80, exp_pend: 20,  exp_err: 0, exp_issue: 0};
    cv[3] = '{len: 0,   drain: 50, exp_pend: 0,   exp_err: 1, exp_issue: 0};
    cv[4] = '{len: 8,   drain: 0,  exp_pend: 8,   exp_err: 1, exp_issue: 1};
    cv[5] = '{len: 0,   drain: 8,  exp_pend: 0,   exp_err: 1, exp_issue: 0};

    vectors = 0; miscompares = 0; cyc = 0; id_ctr = 0;
    for (int i = 0; i < N; i++) begin hd[i] = 0; tl[i] = 0; beat[i] = 0; bub[i] = 0; end
    m_busy = 0; m_err = 0; m_issue = 0; m_src = 0; m_ptr = 0; m_pend = 0; m_ilen = 0;
    out_first = 1'b1; out_hs_cnt = 0; stall_chk_en = 0; stall_hold = 0;
    stall_data = '0; stall_last = 1'b0;
    rst_now = 1; rdy_now = 1; dv_now = 0; dl_now = 0; chk_en = 0; bubbles_en = 0;

    // reset
    cycle();
    chk_en = 1;
    cycle();
    rst_now = 0;
    chk_reset_vals("reset");

    // round robin over four 2-beat writers, two packets each
    clear_log();
    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) push(i, 2, 0, 0);
    run_idle(100);
    chk("rr_count", 64'(glog_src.size()), 64'(8));
    for (int k = 0; k < glog_src.size(); k++) begin
      chk("rr_order", 64'(glog_src[k]), 64'(k % N));
      if (k > 0) chk("rr_gap", 64'(glog_cyc[k] - glog_cyc[k-1]), 64'(3));
    end

    // MRd gated by completion space, other requester proceeds
    push(0, 1, 1, 1024); push(0, 1, 1, 1024); push(0, 1, 1, 1024); push(0, 1, 1, 428);
    run_idle(40);
    chk("pend_3500", 64'(pending_dw), 64'(3500));
    clear_log();
    push(1, 1, 1, 1024);
    push(2, 1, 0, 0);
    run_n(8);
    chk("skip_cnt", 64'(glog_src.size()), 64'(1));
    if (glog_src.size() > 0) chk("skip_src", 64'(glog_src[0]), 64'(2));
    dv_now = 1; dl_now = 600;
    cycle();
    dv_now = 0;
    run_idle(20);
    chk("after_drain_cnt", 64'(glog_src.size()), 64'(2));
    if (glog_src.size() > 1) chk("after_drain_src", 64'(glog_src[1]), 64'(1));
    chk("pend_3924", 64'(pending_dw), 64'(3924));
    drain_all();
    chk("pend_flushed", 64'(pending_dw), 64'(0));

    // counter vector table
    for (int v = 0; v < 6; v++) begin
      if (cv[v].len > 0) push(0, 1, 1, cv[v].len);
      dv_now = (cv[v].drain > 0);
      dl_now = cv[v].drain;
      cycle();
      dv_now = 0;
      chk("vec_pending", 64'(pending_dw), 64'(cv[v].exp_pend));
      chk("vec_err", 64'(err_underflow), 64'(cv[v].exp_err));
      chk("vec_issue", 64'(mrd_issue_valid), 64'(cv[v].exp_issue));
      if (cv[v].len > 0) begin
        chk("vec_issue_len", 64'(mrd_issue_len), 64'(cv[v].len));
        cycle();
        chk("vec_issue_single", 64'(mrd_issue_valid), 64'(0));
      end
      run_idle(10);
    end
    rst_now = 1;
    cycle();
    rst_now = 0;
    chk("err_cleared", 64'(err_underflow), 64'(0));

    // 4-beat TLP with ready toggling; competing source must wait
    push(0, 4, 0, 0);
    push(1, 1, 0, 0);
    rdy_now = 1;
    cycle();
    base = out_hs_cnt;
    stall_chk_en = 1; stall_hold = 0;
    for (int t = 0; t < 7; t++) begin
      rdy_now = (t % 2 == 0);
      cycle();
      chk("hold_src", 64'(out_src), 64'(0));
    end
    chk("hs_count", 64'(out_hs_cnt - base), 64'(4));
    stall_chk_en = 0;
    rdy_now = 1;
    run_idle(10);

    // reset during beat 2 of 4 with credits outstanding
    push(1, 1, 1, 256);
    run_idle(10);
    chk("pend_256", 64'(pending_dw), 64'(256));
    push(3, 4, 0, 0);
    cycle();
    cycle();
    chk("mid_pkt_src", 64'(out_src), 64'(3));
    rst_now = 1;
    cycle();
    rst_now = 0;
    chk_reset_vals("midrst");
    clear_log();
    push(1, 1, 0, 0);
    push(3, 1, 0, 0);
    run_idle(20);
    if (glog_src.size() > 0) chk("post_rst_first", 64'(glog_src[0]), 64'(1));
    else chk("post_rst_first", 64'(glog_src.size()), 64'(2));

    // randomized traffic against the model
    bubbles_en = 1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (qcnt(i) < 4 && $urandom % 8 == 0) begin
          if ($urandom % 3 == 0) push(i, 1, 1, int'($urandom_range(1, 1024)));
          else push(i, int'($urandom_range(1, 4)), 0, 0);
        end
      end
      rdy_now = ($urandom % 4 != 0);
      if ($urandom % 64 == 0) begin
        dv_now = 1;
        dl_now = int'($urandom_range(1, 1024));
      end else if (m_pend > 0 && $urandom % 3 == 0) begin
        dv_now = 1;
        dl_now = int'($urandom_range(1, (m_pend > 1024) ? 1024 : m_pend));
      end else begin
        dv_now = 0;
        dl_now = 0;
      end
      rst_now = ($urandom % 500 == 0);
      cycle();
    end
    rst_now = 0;
    bubbles_en = 0;
    rdy_now = 1;
    drain_all();
    run_idle(200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
